sym_serializer: RTL

Parallel-to-serial stage of the transmit path. Takes 10-bit line symbols through a one-entry valid/ready buffer and shifts them out LSB-first, one bit per `clk` cycle. `clk` is the same high-rate bit clock that feeds the clock-divider block. It sends a fixed comma preamble after enable and inserts comma idles whenever no symbol is buffered at a symbol boundary.

---
 rtl/sym_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sym_serializer.sv
// Parallel-to-serial line stage: one-entry valid/ready hold buffer feeding an LSB-first
// shifter, with a comma preamble after enable and comma idles when no symbol is buffered.
module sym_serializer #(
   parameter int                 SYM_W     = 10,
   parameter int                 SYNC_SYMS = 4,
   parameter logic [SYM_W-1:0]   COMMA     = 10'b0011111010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic [SYM_W-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             sym_start,
   output logic             sync_done
);

   localparam int CNT_W = $clog2(SYM_W);
   localparam int SC_W  = $clog2(SYNC_SYMS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);
   localparam logic [SC_W-1:0]  SYNC_LIM = SC_W'(SYNC_SYMS);

   typedef enum logic [1:0] {OFF, SYNC, DATA} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
   logic [SC_W-1:0]    sync_cnt, sync_cnt_n;
   logic [SYM_W-1:0]   shreg, shreg_n;
   logic [SYM_W-1:0]   hold, hold_n;
   logic               hold_full, hold_full_n;
   logic               ser_n, start_n, sync_done_n;
   logic [SYM_W-1:0]   sym;
   logic               load;

   // Handshake: a symbol transfers at any posedge where data_valid && data_ready.
   // data_ready depends only on registers, never on data_valid.
   assign data_ready = (state != OFF) && !hold_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= OFF;
         bit_cnt   <= '0;
         sync_cnt  <= '0;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         ser_out   <= 1'b0;
         sym_start <= 1'b0;
         sync_done <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         sync_cnt  <= sync_cnt_n;
         shreg     <= shreg_n;
         hold      <= hold_n;
         hold_full <= hold_full_n;
         ser_out   <= ser_n;
         sym_start <= start_n;
         sync_done <= sync_done_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      sync_cnt_n  = sync_cnt;
      shreg_n     = shreg;
      hold_n      = hold;
      hold_full_n = hold_full;
      ser_n       = ser_out;
      start_n     = sym_start;
      sym         = COMMA;
      load        = 1'b0;

      if (data_valid && data_ready) begin
         hold_n      = data_in;
         hold_full_n = 1'b1;
      end

      unique case (state)
         OFF: begin
            if (enb) begin
               state_n    = SYNC;
               sync_cnt_n = SC_W'(1);
               load       = 1'b1;
            end
         end
         default: begin
            if (!enb) begin
               // Disable wins over everything, including a same-cycle handshake.
               state_n     = OFF;
               bit_cnt_n   = '0;
               sync_cnt_n  = '0;
               hold_full_n = 1'b0;
               ser_n       = 1'b0;
               start_n     = 1'b0;
            end else if (bit_cnt == LAST_BIT) begin
               load = 1'b1;
               if (state == SYNC && sync_cnt < SYNC_LIM) begin
                  sync_cnt_n = sync_cnt + 1'b1;
               end else begin
                  state_n = DATA;
                  if (hold_full) begin
                     sym         = hold;
                     hold_full_n = 1'b0;
                  end
               end
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
               ser_n     = shreg[0];
               shreg_n   = {1'b0, shreg[SYM_W-1:1]};
               start_n   = 1'b0;
            end
         end
      endcase

      if (load) begin
         bit_cnt_n = '0;
         ser_n     = sym[0];
         shreg_n   = sym >> 1;
         start_n   = 1'b1;
      end

      sync_done_n = (state_n == DATA);
   end

endmodule
